pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Hazard and sequencing controller for the five-stage Y86-64 pipeline.
- Each cycle it produces the stall and bubble controls for the F, D, E, M and W pipeline registers, and the condition-code write enable.
- It holds a small state machine that flushes the pipe after reset, runs, and freezes on a non-AOK writeback status.
- It works alongside the fetch PC selector: it guarantees that M_icode/M_cnd and W_icode/W_valM reach that selector only for instructions that are allowed to redirect fetch.

Parameters:
- FLUSH_CYCLES, 5, number of post-reset cycles during which D/E/M are bubbled and F is stalled.
- STALL_LIMIT, 16, consecutive F_stall cycles after which stall_err is raised.
- CNT_W, 32, width of the performance counters (used only when PERF_CNT_EN is defined).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- D_icode  in  4  icode in the decode register.
- E_icode  in  4  icode in the execute register.
- M_icode  in  4  icode in the memory register.
- E_dstM  in  4  destination of memory result in execute.
- d_srcA  in  4  decode source register A (4'hF = none).
- d_srcB  in  4  decode source register B.
- e_Cnd  in  1  branch/cmov condition from execute.
- m_stat  in  4  status leaving memory stage.
- W_stat  in  4  status in writeback register.
- F_stall  out  1  hold the F register.
- D_stall  out  1  hold the D register.
- D_bubble  out  1  insert nop into D.
- E_bubble  out  1  insert nop into E.
- M_bubble  out  1  insert nop into M.
- W_stall  out  1  hold the W register.
- set_cc  out  1  condition-code write enable.
- cpu_stat  out  4  registered processor status.
- halted  out  1  registered; 1 once the pipeline is frozen.
- stall_err  out  1  registered sticky watchdog flag.

Behaviour:
- Codes:
  - icode: HALT 0, NOP 1, CMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSH A, POP B.
  - stat: AOK 1, HLT 2, ADR 3, INS 4.
  - "exc(x)" means x ∈ {HLT, ADR, INS}.
- Combinational hazard terms:
  - load_use = (E_icode ∈ {MRMOV, POP}) and E_dstM ≠ F and E_dstM ∈ {d_srcA, d_srcB}.
  - ret_in = RET ∈ {D_icode, E_icode, M_icode}.
  - mispred = E_icode == JXX and !e_Cnd.
- RUN-state outputs (all outputs are combinational from current inputs and state):
  - F_stall = load_use | ret_in.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_in & !load_use).
  - E_bubble = mispred | load_use.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
  - set_cc = E_icode == OPQ & !exc(m_stat) & !exc(W_stat).
- Precedence: load_use with ret_in gives a stall of D, not a bubble. A stall and a bubble are never both asserted on the same register.
- FSM states FLUSH, RUN, HALT. Reset enters FLUSH with the flush count at 0.
  - FLUSH: F_stall = 1; D/E/M_bubble = 1; W_stall = 0; set_cc = 0. After FLUSH_CYCLES cycles, go to RUN.
  - RUN: equations above. exc(W_stat) on a clock edge → HALT, and cpu_stat and halted are latched.
  - HALT: F_stall = 1, D_stall = 1, W_stall = 1, M_bubble = 1, E_bubble = 1, D_bubble = 0, set_cc = 0. Only rst leaves HALT.
- Reset values: cpu_stat = AOK, halted = 0, stall_err = 0, all counters = 0. rst asserted mid-operation aborts any state immediately.
- Watchdog:
  - A counter increments each RUN cycle with F_stall = 1 and clears when F_stall = 0. It saturates at STALL_LIMIT.
  - Reaching STALL_LIMIT sets stall_err, which is sticky until rst.
- cpu_stat: in RUN it tracks W_stat whenever W_stat ≠ 0; it freezes in HALT.

Optional Feature:
- PERF_CNT_EN defined: adds outputs cyc_cnt, ret_cnt (instructions retired: RUN cycles with W_stat == AOK and !W_stall) and bub_cnt (cycles with D_bubble | E_bubble).
  - All three are CNT_W wide, wrap modulo 2^CNT_W, reset to 0, and hold in HALT.
- PERF_CNT_EN undefined: these ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Shared package y86_pkg holds the icode and stat constants and the FSM state encoding.
- One natural sub-module, hazard_detect: the purely combinational load_use, ret_in and mispred terms.
- FSM, watchdog and counters stay in pipe_ctrl.

Test Plan:
- Reset released: FLUSH_CYCLES=5 cycles of F_stall=1 and D/E/M_bubble=1, then RUN. cpu_stat=1, halted=0.
- E_icode=5, E_dstM=3, d_srcA=3: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Same with d_srcA=d_srcB=F: no stall.
- D_icode=9, then E, then M, each for one cycle: F_stall=1 and D_bubble=1 for 3 cycles. With load_use concurrent: D_stall=1, D_bubble=0.
- E_icode=7, e_Cnd=0: D_bubble=1, E_bubble=1, F_stall=0. With e_Cnd=1: no bubbles.
- m_stat=3: M_bubble=1, set_cc=0 even with E_icode=6. Next W_stat=3: W_stall=1, then halted=1, cpu_stat=3; then rst returns to FLUSH.
- Hold load_use for 16 cycles: stall_err=1 at the 16th cycle and stays 1 after load_use clears.

Source files
------------

// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg
//   Shared constants for the Y86-64 pipeline control slice: instruction codes,
//   status codes, the "no register" id, and the pipe_ctrl FSM state encoding.
//   is_exc() classifies a status code as exceptional (HLT, ADR or INS).
// ----------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] R_NONE   = 4'hF;

    // Status codes
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] S_HLT    = 4'h2;
    localparam logic [3:0] S_ADR    = 4'h3;
    localparam logic [3:0] S_INS    = 4'h4;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    function automatic logic is_exc(input logic [3:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
//   Purely combinational pipeline hazard terms.
//   Inputs : D_icode, E_icode, M_icode  - icodes in the D/E/M registers
//            E_dstM                     - memory-result destination in E
//            d_srcA, d_srcB             - decode source registers
//            e_Cnd                      - branch condition from execute
//   Outputs: load_use - load in E feeds a source being read in decode
//            ret_in   - a RET is somewhere in D, E or M
//            mispred  - conditional jump in E was predicted taken but is not
// ----------------------------------------------------------------------------
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] E_dstM,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic       e_Cnd,
    output logic       load_use,
    output logic       ret_in,
    output logic       mispred
);

    // E_dstM == R_NONE must never match, even when a source is also R_NONE.
    assign load_use = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                      (E_dstM != R_NONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    assign ret_in   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

    assign mispred  = (E_icode == I_JXX) && !e_Cnd;

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//   Hazard and sequencing controller for the five-stage Y86-64 pipeline.
//   Drives stall/bubble controls for F/D/E/M/W and the condition-code enable,
//   flushes the pipe after reset, and freezes on a non-AOK writeback status.
//
//   Ports:
//     clk, rst                 - clock (rising edge), async active-high reset
//     D_icode/E_icode/M_icode  - icodes in the D/E/M registers
//     E_dstM, d_srcA, d_srcB   - load-use operands
//     e_Cnd                    - branch condition from execute
//     m_stat, W_stat           - status leaving memory / in writeback
//     F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
//                              - combinational pipeline controls
//     cpu_stat, halted         - registered processor status / frozen flag
//     stall_err                - registered sticky fetch-stall watchdog
//
//   Optional build macro PERF_CNT_EN adds CNT_W-wide counters cyc_cnt,
//   ret_cnt and bub_cnt; they hold while halted.
// ----------------------------------------------------------------------------
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int FLUSH_CYCLES = 5,
    parameter int STALL_LIMIT  = 16
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [3:0]       cpu_stat,
    output logic             halted,
    output logic             stall_err
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] bub_cnt
`endif
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam int WD_W = $clog2(STALL_LIMIT + 1);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_LIMIT);
    localparam logic [WD_W-1:0] WD_PRE   = WD_W'(STALL_LIMIT - 1);

    state_t          state;
    logic [FC_W-1:0] flush_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic load_use;
    logic ret_in;
    logic mispred;
    logic m_exc;
    logic w_exc;

    hazard_detect u_hazard (
        .D_icode  (D_icode),
        .E_icode  (E_icode),
        .M_icode  (M_icode),
        .E_dstM   (E_dstM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .e_Cnd    (e_Cnd),
        .load_use (load_use),
        .ret_in   (ret_in),
        .mispred  (mispred)
    );

    assign m_exc = is_exc(m_stat);
    assign w_exc = is_exc(W_stat);

    // Pipeline controls. A RET waiting behind a load-use stall keeps D held
    // rather than bubbled, so D never sees stall and bubble together.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        case (state)
            ST_FLUSH: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            ST_RUN: begin
                F_stall  = load_use | ret_in;
                D_stall  = load_use;
                D_bubble = mispred | (ret_in & ~load_use);
                E_bubble = mispred | load_use;
                M_bubble = m_exc | w_exc;
                W_stall  = w_exc;
                set_cc   = (E_icode == I_OPQ) & ~m_exc & ~w_exc;
            end
            ST_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM, status capture and fetch-stall watchdog.
    // NOTE: reset is asynchronous so asserting rst aborts any state at once, not at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            cpu_stat  <= S_AOK;
            halted    <= 1'b0;
            wd_cnt    <= '0;
            stall_err <= 1'b0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    if (flush_cnt == FC_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (W_stat != 4'h0) begin
                        cpu_stat <= W_stat;
                    end
                    if (w_exc) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                    if (F_stall) begin
                        if (wd_cnt != WD_LIMIT) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                        // Set on the edge where the count reaches the limit.
                        if (wd_cnt == WD_PRE) begin
                            stall_err <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                ST_HALT: ;
                default: state <= ST_FLUSH;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
            bub_cnt <= '0;
        end else if (state != ST_HALT) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if ((state == ST_RUN) && (W_stat == S_AOK) && !W_stall) begin
                ret_cnt <= ret_cnt + 1'b1;
            end
            if (D_bubble || E_bubble) begin
                bub_cnt <= bub_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed self-checking bench for pipe_ctrl. Control outputs are packed as
//   ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
    logic       e_Cnd;
    logic [3:0] m_stat, W_stat;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic [3:0] cpu_stat;
    logic       halted, stall_err;
`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt, bub_cnt;
`endif

    logic [6:0] ctl;
    assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .D_icode   (D_icode),
        .E_icode   (E_icode),
        .M_icode   (M_icode),
        .E_dstM    (E_dstM),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .e_Cnd     (e_Cnd),
        .m_stat    (m_stat),
        .W_stat    (W_stat),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .W_stall   (W_stall),
        .set_cc    (set_cc),
        .cpu_stat  (cpu_stat),
        .halted    (halted),
        .stall_err (stall_err)
`ifdef PERF_CNT_EN
        ,
        .cyc_cnt   (cyc_cnt),
        .ret_cnt   (ret_cnt),
        .bub_cnt   (bub_cnt)
`endif
    );

    localparam logic [6:0] CTL_FLUSH = 7'b1011100;
    localparam logic [6:0] CTL_IDLE  = 7'b0000000;
    localparam logic [6:0] CTL_LU    = 7'b1101000;
    localparam logic [6:0] CTL_RET   = 7'b1010000;
    localparam logic [6:0] CTL_MISP  = 7'b0011000;
    localparam logic [6:0] CTL_OPQ   = 7'b0000001;
    localparam logic [6:0] CTL_MEXC  = 7'b0000100;
    localparam logic [6:0] CTL_WEXC  = 7'b0000110;
    localparam logic [6:0] CTL_HALT  = 7'b1101110;

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        E_dstM  = 4'hF; d_srcA  = 4'hF; d_srcB  = 4'hF;
        e_Cnd   = 1'b0; m_stat  = 4'h1; W_stat  = 4'h1;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (ctl !== CTL_FLUSH) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_FLUSH);
        end
        checks++;
        if (cpu_stat !== 4'h1 || halted !== 1'b0 || stall_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got cpu_stat=%0h halted=%b stall_err=%b expected 1 0 0",
                     cpu_stat, halted, stall_err);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_FLUSH) begin
                errors++; $display("FAIL flush_cycle%0d: got %b expected %b", i, ctl, CTL_FLUSH);
            end
            tick();
        end
        #1;
        checks++;
        if (ctl !== CTL_IDLE || cpu_stat !== 4'h1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL run_entry: got ctl=%b cpu_stat=%0h halted=%b expected %b 1 0",
                     ctl, cpu_stat, halted, CTL_IDLE);
        end
    endtask

    task automatic test_load_use();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL load_use_srcA: got %b expected %b", ctl, CTL_LU);
        end
        E_icode = 4'hB; d_srcA = 4'hF; d_srcB = 4'h3;
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL load_use_pop_srcB: got %b expected %b", ctl, CTL_LU);
        end
        E_icode = 4'h5; d_srcA = 4'hF; d_srcB = 4'hF;
        #1;
        checks++;
        if (ctl !== CTL_IDLE) begin
            errors++; $display("FAIL load_use_no_src: got %b expected %b", ctl, CTL_IDLE);
        end
        E_dstM = 4'hF;
        #1;
        checks++;
        if (ctl !== CTL_IDLE) begin
            errors++; $display("FAIL load_use_dstM_none: got %b expected %b", ctl, CTL_IDLE);
        end
        idle();
        tick();
    endtask

    task automatic test_ret();
        logic [3:0] pos [3];
        pos[0] = 4'h9; pos[1] = 4'h1; pos[2] = 4'h1;
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 0) D_icode = 4'h9;
            if (i == 1) E_icode = 4'h9;
            if (i == 2) M_icode = 4'h9;
            #1;
            checks++;
            if (ctl !== CTL_RET) begin
                errors++; $display("FAIL ret_stage%0d: got %b expected %b", i, ctl, CTL_RET);
            end
            tick();
        end
        idle();
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL ret_with_load_use: got %b expected %b", ctl, CTL_LU);
        end
        idle();
        tick();
    endtask

    task automatic test_mispred();
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_MISP) begin
            errors++; $display("FAIL mispred_not_taken: got %b expected %b", ctl, CTL_MISP);
        end
        e_Cnd = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_IDLE) begin
            errors++; $display("FAIL mispred_taken: got %b expected %b", ctl, CTL_IDLE);
        end
        idle();
        tick();
    endtask

    task automatic test_exception_halt();
        E_icode = 4'h6;
        #1;
        checks++;
        if (ctl !== CTL_OPQ) begin
            errors++; $display("FAIL set_cc_opq: got %b expected %b", ctl, CTL_OPQ);
        end
        m_stat = 4'h3;
        #1;
        checks++;
        if (ctl !== CTL_MEXC) begin
            errors++; $display("FAIL m_exc: got %b expected %b", ctl, CTL_MEXC);
        end
        tick();
        idle();
        W_stat = 4'h3;
        #1;
        checks++;
        if (ctl !== CTL_WEXC || halted !== 1'b0) begin
            errors++;
            $display("FAIL w_exc: got ctl=%b halted=%b expected %b 0", ctl, halted, CTL_WEXC);
        end
        tick();
        idle();
        E_icode = 4'h6;
        #1;
        checks++;
        if (ctl !== CTL_HALT || halted !== 1'b1 || cpu_stat !== 4'h3) begin
            errors++;
            $display("FAIL halt_entry: got ctl=%b halted=%b cpu_stat=%0h expected %b 1 3",
                     ctl, halted, cpu_stat, CTL_HALT);
        end
        tick();
        tick();
        checks++;
        if (ctl !== CTL_HALT || cpu_stat !== 4'h3) begin
            errors++;
            $display("FAIL halt_frozen: got ctl=%b cpu_stat=%0h expected %b 3",
                     ctl, cpu_stat, CTL_HALT);
        end
        idle();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_FLUSH || halted !== 1'b0 || cpu_stat !== 4'h1) begin
            errors++;
            $display("FAIL halt_reset: got ctl=%b halted=%b cpu_stat=%0h expected %b 0 1",
                     ctl, halted, cpu_stat, CTL_FLUSH);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (ctl !== CTL_IDLE) begin
            errors++; $display("FAIL rerun_entry: got %b expected %b", ctl, CTL_IDLE);
        end
    endtask

    task automatic test_watchdog();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i >= 15) begin
                checks++;
                if (stall_err !== (i == 16)) begin
                    errors++;
                    $display("FAIL watchdog_cycle%0d: got %b expected %b", i, stall_err, (i == 16));
                end
            end
        end
        idle();
        tick();
        tick();
        checks++;
        if (stall_err !== 1'b1 || ctl !== CTL_IDLE) begin
            errors++;
            $display("FAIL watchdog_sticky: got stall_err=%b ctl=%b expected 1 %b",
                     stall_err, ctl, CTL_IDLE);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_ret();
        test_mispred();
        test_exception_halt();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
